rd53_lbnl_fe_control: RTL and testbench

Pixel-side controller for the LBNL analog front end: drives the AFE digital controls (S0, S1, DTH1, DTH2) from a configuration write port and consumes the active-low discriminator output outdis. It synchronizes outdis, measures time-over-threshold (ToT) in CLK cycles, and presents each hit on a valid/ready port to the pixel-region logic. It sits between the AFE digital interface (fe_control side) and the region buffer.

---
 rtl/rd53_lbnl_fe_pkg.sv | 18 +
 rtl/rd53_lbnl_fe_control_if.sv | 25 ++
 rtl/rd53_lbnl_disc_sync.sv | 31 +++
 rtl/rd53_lbnl_fe_control.sv | 148 ++++++++++++++
 tb/tb_rd53_lbnl_fe_control.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rd53_lbnl_fe_pkg.sv
// Shared definitions for the LBNL front-end pixel controller:
// cfg_data field layout, FSM state encoding and default ToT width.
package rd53_lbnl_fe_pkg;

  localparam int unsigned CFG_W         = 10;
  localparam int unsigned DTH1_LSB      = 0;
  localparam int unsigned DTH2_LSB      = 4;
  localparam int unsigned S0_BIT        = 8;
  localparam int unsigned S1_BIT        = 9;
  localparam int unsigned TOT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } fe_state_t;

endpackage

// File: rtl/rd53_lbnl_fe_control_if.sv
// Hit word port between the pixel controller (master) and the
// pixel-region buffer (slave): valid/ready handshake plus ToT payload.
interface rd53_lbnl_fe_control_if
  import rd53_lbnl_fe_pkg::*;
#(
  parameter int unsigned TOT_W = TOT_W_DEFAULT
) ();

  logic             hit_valid;
  logic             hit_ready;
  logic [TOT_W-1:0] hit_tot;

  modport master (
    output hit_valid,
    output hit_tot,
    input  hit_ready
  );

  modport slave (
    input  hit_valid,
    input  hit_tot,
    output hit_ready
  );

endinterface

// File: rtl/rd53_lbnl_disc_sync.sv
// Synchronizer for the asynchronous, active-low discriminator output.
// Flops reset to 1 (outdis idle-high) so disc starts at 0; rise flags
// the first cycle of each synchronized pulse.
module rd53_lbnl_disc_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_B,
  input  logic outdis,
  output logic disc,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   disc_q;

  // Shift outdis through the synchronizer and keep last disc for edge detection
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      sync_q <= '1;
      disc_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], outdis};
      disc_q <= disc;
    end
  end

  assign disc = ~sync_q[SYNC_STAGES-1];
  assign rise = disc & ~disc_q;

endmodule

// File: rtl/rd53_lbnl_fe_control.sv
// Pixel-side controller for the LBNL analog front end.
// Holds AFE control registers (S0, S1, DTH1, DTH2), measures ToT of the
// synchronized discriminator pulse and offers each hit on a valid/ready
// port; pulses arriving while a hit is pending are counted as lost.
// Optional feature macro: RD53_LBNL_FE_HITOR_EN (registered fast-OR).
module rd53_lbnl_fe_control
  import rd53_lbnl_fe_pkg::*;
#(
  parameter int unsigned TOT_W       = TOT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOST_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  input  logic                  cfg_we,
  input  logic [CFG_W-1:0]      cfg_data,
  input  logic                  enable,
  output logic                  S0,
  output logic                  S1,
  output logic [3:0]            DTH1,
  output logic [3:0]            DTH2,
  input  logic                  outdis,
  rd53_lbnl_fe_control_if.master hit_if,
  output logic [LOST_W-1:0]     lost_cnt,
  input  logic                  lost_clr,
  output logic                  hitor
);

  localparam logic [TOT_W-1:0]  TOT_MAX  = '1;
  localparam logic [LOST_W-1:0] LOST_MAX = '1;

  logic             disc;
  logic             rise;
  fe_state_t        state_q, state_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [TOT_W-1:0] hit_tot_q, hit_tot_d;
  logic             hit_valid_q, hit_valid_d;
  logic             lost_inc;
  logic [LOST_W-1:0] lost_q;

  rd53_lbnl_disc_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_disc_sync (
    .CLK   (CLK),
    .RST_B (RST_B),
    .outdis(outdis),
    .disc  (disc),
    .rise  (rise)
  );

  // AFE control registers, loaded as a whole on every config write
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      S0   <= 1'b0;
      S1   <= 1'b0;
      DTH1 <= 4'h0;
      DTH2 <= 4'h0;
    end else if (cfg_we) begin
      S0   <= cfg_data[S0_BIT];
      S1   <= cfg_data[S1_BIT];
      DTH1 <= cfg_data[DTH1_LSB +: 4];
      DTH2 <= cfg_data[DTH2_LSB +: 4];
    end
  end

  // FSM and ToT datapath registers
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state_q     <= IDLE;
      tot_q       <= '0;
      hit_tot_q   <= '0;
      hit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tot_q       <= tot_d;
      hit_tot_q   <= hit_tot_d;
      hit_valid_q <= hit_valid_d;
    end
  end

  // Next state: start on a new enabled rise, count while disc, hold until handshake
  always_comb begin
    state_d     = state_q;
    tot_d       = tot_q;
    hit_tot_d   = hit_tot_q;
    hit_valid_d = hit_valid_q;
    lost_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise && enable) begin
          state_d = COUNT;
          tot_d   = TOT_W'(1);
        end
      end
      COUNT: begin
        // masking aborts the measurement even on the pulse's final cycle
        if (!enable) begin
          state_d = IDLE;
          tot_d   = '0;
        end else if (disc) begin
          if (tot_q != TOT_MAX) tot_d = tot_q + TOT_W'(1);
        end else begin
          state_d     = HOLD;
          hit_tot_d   = tot_q;
          hit_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (rise && enable) lost_inc = 1'b1;
        if (hit_valid_q && hit_if.hit_ready) begin
          state_d     = IDLE;
          hit_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating lost-hit counter; clear wins over a coincident increment
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      lost_q <= '0;
    end else if (lost_clr) begin
      lost_q <= '0;
    end else if (lost_inc && (lost_q != LOST_MAX)) begin
      lost_q <= lost_q + LOST_W'(1);
    end
  end

`ifdef RD53_LBNL_FE_HITOR_EN
  logic hitor_q;

  // Fast-OR follows the masked discriminator one cycle later, FSM-independent
  always_ff @(posedge CLK) begin
    if (!RST_B) hitor_q <= 1'b0;
    else        hitor_q <= disc & enable;
  end

  assign hitor = hitor_q;
`else
  assign hitor = 1'b0;
`endif

  assign hit_if.hit_valid = hit_valid_q;
  assign hit_if.hit_tot   = hit_tot_q;
  assign lost_cnt         = lost_q;

endmodule

// File: tb/tb_rd53_lbnl_fe_control.sv
// Bench for rd53_lbnl_fe_control: directed stimulus pushes expected ToT
// values into a queue; a monitor compares hit_tot whenever hit_valid is
// high and pops on each completed handshake.
module tb_rd53_lbnl_fe_control;
  import rd53_lbnl_fe_pkg::*;

  localparam int unsigned TOT_W = 4;
`ifdef RD53_LBNL_FE_HITOR_EN
  localparam int HITOR_ON = 1;
`else
  localparam int HITOR_ON = 0;
`endif

  logic             CLK      = 1'b0;
  logic             RST_B    = 1'b0;
  logic             cfg_we   = 1'b0;
  logic [CFG_W-1:0] cfg_data = '0;
  logic             enable   = 1'b0;
  logic             S0, S1;
  logic [3:0]       DTH1, DTH2;
  logic             outdis   = 1'b1;
  logic [7:0]       lost_cnt;
  logic             lost_clr = 1'b0;
  logic             hitor;

  rd53_lbnl_fe_control_if #(.TOT_W(TOT_W)) hit_if ();

  rd53_lbnl_fe_control #(
    .TOT_W      (TOT_W),
    .SYNC_STAGES(2),
    .LOST_W     (8)
  ) dut (
    .CLK     (CLK),
    .RST_B   (RST_B),
    .cfg_we  (cfg_we),
    .cfg_data(cfg_data),
    .enable  (enable),
    .S0      (S0),
    .S1      (S1),
    .DTH1    (DTH1),
    .DTH2    (DTH2),
    .outdis  (outdis),
    .hit_if  (hit_if.master),
    .lost_cnt(lost_cnt),
    .lost_clr(lost_clr),
    .hitor   (hitor)
  );

  always #5 CLK = ~CLK;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [TOT_W-1:0] exp_q[$];
  bit               done  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // outdis sampled low at exactly n consecutive edges
  task automatic pulse(input int n);
    @(posedge CLK);
    #1 outdis = 1'b0;
    repeat (n) @(posedge CLK);
    #1 outdis = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int i = 0;
    while (!hit_if.hit_valid && i < 100) begin
      @(posedge CLK);
      #1;
      i++;
    end
    check(name, int'(hit_if.hit_valid), 1);
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (hit_if.hit_valid && i < 100) begin
      @(posedge CLK);
      #1;
      i++;
    end
    check(name, int'(hit_if.hit_valid), 0);
  endtask

  initial begin
    hit_if.hit_ready = 1'b0;
    fork
      begin : stimulus
        // reset values
        repeat (2) @(posedge CLK);
        #1 RST_B = 1'b1;
        @(negedge CLK);
        check("rst_ctrl", int'({S1, S0, DTH2, DTH1}), 0);
        check("rst_valid", int'(hit_if.hit_valid), 0);
        check("rst_tot", int'(hit_if.hit_tot), 0);
        check("rst_lost", int'(lost_cnt), 0);
        check("rst_hitor", int'(hitor), 0);

        // config write and reset of the control registers
        @(posedge CLK);
        #1 cfg_we = 1'b1; cfg_data = 10'h2A5;
        @(posedge CLK);
        #1 cfg_we = 1'b0;
        @(negedge CLK);
        check("cfg_s1", int'(S1), 1);
        check("cfg_s0", int'(S0), 0);
        check("cfg_dth2", int'(DTH2), 'hA);
        check("cfg_dth1", int'(DTH1), 'h5);
        @(posedge CLK);
        #1 RST_B = 1'b0;
        @(posedge CLK);
        #1 RST_B = 1'b1;
        @(negedge CLK);
        check("cfg_after_rst", int'({S1, S0, DTH2, DTH1}), 0);

        // basic hit with latency and single-cycle valid
        @(posedge CLK);
        #1 enable = 1'b1; hit_if.hit_ready = 1'b1;
        idle(3);
        exp_q.push_back(4'd6);
        pulse(6);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("lat_valid_early", int'(hit_if.hit_valid), 0);
        check("hitor_high", int'(hitor), HITOR_ON);
        @(negedge CLK);
        check("lat_valid_on", int'(hit_if.hit_valid), 1);
        check("hitor_low", int'(hitor), 0);
        @(negedge CLK);
        check("valid_one_cycle", int'(hit_if.hit_valid), 0);
        idle(2);

        // saturation
        exp_q.push_back(4'd15);
        pulse(40);
        wait_valid("sat_valid");
        wait_idle("sat_idle");
        idle(2);

        // backpressure: two lost pulses, then clear coinciding with a third
        hit_if.hit_ready = 1'b0;
        exp_q.push_back(4'd5);
        pulse(5);
        wait_valid("bp_valid");
        idle(3);
        pulse(3);
        idle(3);
        pulse(3);
        idle(4);
        check("lost_two", int'(lost_cnt), 2);
        lost_clr = 1'b1;
        pulse(3);
        idle(4);
        lost_clr = 1'b0;
        @(negedge CLK);
        check("lost_cleared", int'(lost_cnt), 0);
        check("bp_still_valid", int'(hit_if.hit_valid), 1);
        @(posedge CLK);
        #1 hit_if.hit_ready = 1'b1;
        wait_idle("bp_release");
        idle(2);

        // masked pulse
        enable = 1'b0;
        pulse(4);
        idle(6);
        @(negedge CLK);
        check("mask_no_hit", int'(hit_if.hit_valid), 0);
        @(posedge CLK);
        #1 enable = 1'b1;
        idle(2);

        // enable dropped mid-COUNT; remainder of the pulse must be ignored
        outdis = 1'b0;
        repeat (5) @(posedge CLK);
        #1 enable = 1'b0;
        @(posedge CLK);
        #1 enable = 1'b1;
        repeat (4) @(posedge CLK);
        #1 outdis = 1'b1;
        idle(6);
        @(negedge CLK);
        check("abort_no_hit", int'(hit_if.hit_valid), 0);
        @(posedge CLK);
        #1;
        exp_q.push_back(4'd3);
        pulse(3);
        wait_valid("post_abort_valid");
        wait_idle("post_abort_idle");
        idle(2);

        // reset while a hit is pending
        hit_if.hit_ready = 1'b0;
        exp_q.push_back(4'd4);
        pulse(4);
        wait_valid("rh_valid");
        idle(2);
        RST_B = 1'b0;
        @(posedge CLK);
        #1 RST_B = 1'b1;
        void'(exp_q.pop_front());
        @(negedge CLK);
        check("rh_valid_drop", int'(hit_if.hit_valid), 0);
        check("rh_tot_zero", int'(hit_if.hit_tot), 0);
        @(posedge CLK);
        #1 hit_if.hit_ready = 1'b1;
        exp_q.push_back(4'd2);
        pulse(2);
        wait_valid("rh_next_valid");
        wait_idle("rh_next_idle");

        idle(4);
        check("scoreboard_empty", exp_q.size(), 0);
        done = 1'b1;
      end
      begin : monitor
        while (!done) begin
          @(negedge CLK);
          if (RST_B && hit_if.hit_valid) begin
            if (exp_q.size() == 0) begin
              check("unexpected_hit", int'(hit_if.hit_valid), 0);
            end else begin
              check("hit_tot", int'(hit_if.hit_tot), int'(exp_q[0]));
              if (hit_if.hit_ready) void'(exp_q.pop_front());
            end
          end
        end
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
